// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the instruction-fetch / load-store memory bus
// arbiter: FSM state encoding, grant-source encoding, default widths and the
// fetch starvation limit, plus the grant-selection helper.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF      = 64;
   localparam int unsigned DATA_W_DEF      = 64;
   localparam int unsigned INSTR_W_DEF     = 32;
   localparam int unsigned MAX_IF_WAIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE_IF  = 2'd1,
      SERVE_MEM = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IF  = 1'b0,
      GNT_MEM = 1'b1
   } gnt_src_t;

   // Pick the winner among eligible requesters. Only meaningful when at least
   // one requester is eligible. MEM wins a tie unless fetch has been passed
   // over often enough to saturate its starvation counter.
   function automatic gnt_src_t arb_pick(input logic if_elig,
                                         input logic mem_elig,
                                         input logic if_sat);
      gnt_src_t g;
      if (!mem_elig) begin
         g = GNT_IF;
      end else if (if_elig && if_sat) begin
         g = GNT_IF;
      end else begin
         g = GNT_MEM;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// mem_arb_starve_cnt
// Saturating up-counter that tracks how many times a pending fetch has been
// passed over in favour of a load/store.
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset (clears the count)
//   inc_i  : count one more pass-over (ignored once saturated)
//   clr_i  : clear the count (fetch was granted); wins over inc_i
//   sat_o  : count has reached LIMIT
// ---------------------------------------------------------------------------
module mem_arb_starve_cnt #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < LIMIT_C)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-ported, variable-latency memory bus between the pipeline's
// instruction-fetch port and its load/store port. One transaction at a time:
// the winner's address/we/wdata are captured at grant and driven onto the bus
// until bus_ready; the following cycle raises a one-cycle done pulse and
// registers the read data. Load/store has priority; fetch gets forced priority
// once it has been passed over MAX_IF_WAIT times.
//   clk, rst              : clock (rising edge), sync active-low reset
//   if_req/if_addr        : fetch request (level) and byte address
//   if_rdata/if_done      : fetched instruction, completion pulse
//   mem_req/we/addr/wdata : load/store request (level) and its payload
//   mem_rdata/mem_done    : load data, completion pulse
//   stall_if/stall_mem    : request pending and not yet done (combinational)
//   bus_req/we/addr/wdata : bus transaction outputs
//   bus_ready/bus_rdata   : bus completion handshake and read data
// ---------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned INSTR_W     = INSTR_W_DEF,
   parameter int unsigned MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic [INSTR_W-1:0] if_rdata,
   output logic               if_done,
   input  logic               mem_req,
   input  logic               mem_we,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_wdata,
   output logic [DATA_W-1:0]  mem_rdata,
   output logic               mem_done,
   output logic               stall_if,
   output logic               stall_mem,
   output logic               bus_req,
   output logic               bus_we,
   output logic [ADDR_W-1:0]  bus_addr,
   output logic [DATA_W-1:0]  bus_wdata,
   input  logic               bus_ready,
   input  logic [DATA_W-1:0]  bus_rdata
);

   arb_state_t         state_q,     state_d;
   logic [ADDR_W-1:0]  addr_q,      addr_d;
   logic               we_q,        we_d;
   logic [DATA_W-1:0]  wdata_q,     wdata_d;
   logic [INSTR_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
   logic               if_done_q,   if_done_d;
   logic               mem_done_q,  mem_done_d;

   logic     if_elig_s;
   logic     mem_elig_s;
   logic     if_sat_s;
   logic     cnt_inc_s;
   logic     cnt_clr_s;
   gnt_src_t gnt_s;

   // A requester whose done is high this cycle still shows its old level;
   // masking it here stops that stale request from being granted again.
   assign if_elig_s  = if_req  & ~if_done_q;
   assign mem_elig_s = mem_req & ~mem_done_q;

   mem_arb_starve_cnt #(
      .LIMIT (MAX_IF_WAIT)
   ) u_starve_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (cnt_inc_s),
      .clr_i (cnt_clr_s),
      .sat_o (if_sat_s)
   );

   // Grant / serve FSM next-state, capture and completion logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      cnt_inc_s   = 1'b0;
      cnt_clr_s   = 1'b0;
      gnt_s       = GNT_MEM;

      case (state_q)
         IDLE: begin
            if (if_elig_s || mem_elig_s) begin
               gnt_s = arb_pick(if_elig_s, mem_elig_s, if_sat_s);
               if (gnt_s == GNT_IF) begin
                  state_d   = SERVE_IF;
                  addr_d    = if_addr;
                  we_d      = 1'b0;
                  wdata_d   = '0;
                  cnt_clr_s = 1'b1;
               end else begin
                  state_d   = SERVE_MEM;
                  addr_d    = mem_addr;
                  we_d      = mem_we;
                  wdata_d   = mem_wdata;
                  // Fetch was waiting and lost this round.
                  cnt_inc_s = if_elig_s;
               end
            end else begin
               state_d = IDLE;
            end
         end

         SERVE_IF: begin
            if (bus_ready) begin
               state_d   = IDLE;
               if_done_d = 1'b1;
               // Little-endian: address bit 2 selects the upper instruction word.
               if (addr_q[2]) begin
                  if_rdata_d = bus_rdata[2*INSTR_W-1 -: INSTR_W];
               end else begin
                  if_rdata_d = bus_rdata[INSTR_W-1:0];
               end
            end else begin
               state_d = SERVE_IF;
            end
         end

         SERVE_MEM: begin
            if (bus_ready) begin
               state_d    = IDLE;
               mem_done_d = 1'b1;
               // Stores leave the last load data untouched.
               if (!we_q) begin
                  mem_rdata_d = bus_rdata;
               end else begin
                  mem_rdata_d = mem_rdata_q;
               end
            end else begin
               state_d = SERVE_MEM;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
      end
   end

   assign bus_req   = (state_q == SERVE_IF) || (state_q == SERVE_MEM);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_done   = if_done_q;
   assign mem_done  = mem_done_q;
   assign stall_if  = if_req  & ~if_done_q;
   assign stall_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by randomized requesters/bus, every cycle
// compared against a transaction-level reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_done, mem_req, mem_we, mem_done;
   logic [63:0] if_addr, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] if_rdata;
   logic        stall_if, stall_mem, bus_req, bus_we, bus_ready;
   logic [63:0] bus_addr, bus_wdata, bus_rdata;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ready (bus_ready),
      .bus_rdata (bus_rdata)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the bus (0 none, 1 fetch, 2 load/store), the
   // transaction captured at grant, the registered results and pass-over count.
   int          owner;
   logic [63:0] r_addr, r_wdata, r_memrd;
   logic        r_we, r_ifd, r_memd;
   logic [31:0] r_ifrd;
   int          if_passed;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs present now.
   task automatic model_edge();
      bit ie, me;
      if (!rst) begin
         owner = 0; r_addr = '0; r_wdata = '0; r_we = 1'b0;
         r_ifrd = '0; r_memrd = '0; r_ifd = 1'b0; r_memd = 1'b0; if_passed = 0;
      end else if (owner != 0) begin
         r_ifd = 1'b0; r_memd = 1'b0;
         if (bus_ready) begin
            if (owner == 1) begin
               r_ifd  = 1'b1;
               r_ifrd = r_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0];
            end else begin
               r_memd = 1'b1;
               if (!r_we) r_memrd = bus_rdata;
            end
            owner = 0;
         end
      end else begin
         ie = if_req && !r_ifd;
         me = mem_req && !r_memd;
         r_ifd = 1'b0; r_memd = 1'b0;
         if (ie && (!me || if_passed >= MAXW)) begin
            owner = 1; r_addr = if_addr; r_we = 1'b0; r_wdata = '0; if_passed = 0;
         end else if (me) begin
            owner = 2; r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata;
            if (ie && if_passed < MAXW) if_passed++;
         end
      end
   endtask

   task automatic check_all();
      chk("bus_req",   64'(bus_req),   64'(owner != 0));
      chk("bus_we",    64'(bus_we),    64'(r_we));
      chk("bus_addr",  bus_addr,       r_addr);
      chk("bus_wdata", bus_wdata,      r_wdata);
      chk("if_rdata",  64'(if_rdata),  64'(r_ifrd));
      chk("mem_rdata", mem_rdata,      r_memrd);
      chk("if_done",   64'(if_done),   64'(r_ifd));
      chk("mem_done",  64'(mem_done),  64'(r_memd));
      chk("stall_if",  64'(stall_if),  64'(if_req & ~r_ifd));
      chk("stall_mem", 64'(stall_mem), 64'(mem_req & ~r_memd));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int n;
      int last_done;
      int cyc;
      rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_addr = '0; mem_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;

      // Reset state.
      tick(); tick();
      chk("rst_bus_req", 64'(bus_req), 64'd0);
      rst = 1'b1;
      tick();

      // Single fetch: done in the third cycle of the request, upper word.
      if_addr = 64'h104; if_req = 1'b1; bus_ready = 1'b1;
      bus_rdata = 64'hAAAA_BBBB_1111_2222;
      tick();
      chk("fetch_bus_addr", bus_addr, 64'h104);
      n = 1;
      while (!if_done && n < 20) begin tick(); n++; end
      chk("fetch_latency", 64'(n), 64'd2);
      chk("fetch_rdata", 64'(if_rdata), 64'hAAAABBBB);
      if_req = 1'b0;
      tick();

      // Simultaneous fetch and store: store first, fetch granted in done cycle.
      if_addr = 64'h200; if_req = 1'b1;
      mem_addr = 64'h8; mem_we = 1'b1; mem_wdata = 64'hDEAD; mem_req = 1'b1;
      tick();
      chk("both_store_we", 64'(bus_we), 64'd1);
      chk("both_store_wdata", bus_wdata, 64'hDEAD);
      tick();
      chk("both_mem_done", 64'(mem_done), 64'd1);
      tick();
      chk("both_if_addr", bus_addr, 64'h200);
      chk("both_if_we", 64'(bus_we), 64'd0);
      mem_req = 1'b0;
      n = 0;
      while (!if_done && n < 20) begin tick(); n++; end
      chk("both_if_done", 64'(if_done), 64'd1);
      if_req = 1'b0;
      tick();

      // Fetch held while load/store keeps re-requesting.
      if_addr = 64'h1000; if_req = 1'b1;
      mem_we = 1'b0; mem_addr = 64'h2000; mem_req = 1'b1;
      for (int k = 0; k < 24; k++) begin
         if (mem_done) mem_addr = mem_addr + 64'h8;
         if (if_done) if_addr = if_addr + 64'h4;
         bus_rdata = {$urandom, $urandom};
         tick();
      end
      if_req = 1'b0; mem_req = 1'b0;
      tick(); tick(); tick();

      // Wait states: address stable for all six bus cycles.
      mem_addr = 64'h20; mem_we = 1'b0; mem_req = 1'b1; bus_ready = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("ws_bus_addr", bus_addr, 64'h20);
         chk("ws_stall_mem", 64'(stall_mem), 64'd1);
         tick();
      end
      chk("ws_bus_addr", bus_addr, 64'h20);
      bus_ready = 1'b1; bus_rdata = 64'h0123;
      tick();
      chk("ws_mem_done", 64'(mem_done), 64'd1);
      chk("ws_mem_rdata", mem_rdata, 64'h0123);
      mem_req = 1'b0;
      tick();

      // Reset mid-transaction: abandoned, no done afterwards.
      mem_addr = 64'h40; mem_req = 1'b1; bus_ready = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("midrst_bus_req", 64'(bus_req), 64'd0);
      chk("midrst_bus_addr", bus_addr, 64'd0);
      chk("midrst_mem_rdata", mem_rdata, 64'd0);
      rst = 1'b1; mem_req = 1'b0; bus_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("midrst_no_done", 64'(mem_done), 64'd0);
      end

      // Back-to-back fetches: done pulses at least three cycles apart.
      if_addr = 64'h3000; if_req = 1'b1; bus_ready = 1'b1;
      last_done = -100; cyc = 0;
      for (int k = 0; k < 16; k++) begin
         tick(); cyc++;
         if (if_done) begin
            if (last_done >= 0) chk("b2b_gap_ge3", 64'(cyc - last_done >= 3), 64'd1);
            last_done = cyc;
            if_addr = if_addr + 64'h4;
         end
      end
      if_req = 1'b0;
      tick();

      // Randomized requesters, bus latency and occasional resets.
      for (int k = 0; k < 600; k++) begin
         bus_ready = ($urandom_range(0, 2) != 0);
         bus_rdata = {$urandom, $urandom};
         rst = ($urandom_range(0, 99) != 0);
         tick();
         if (if_done) begin
            if ($urandom_range(0, 1) == 0) if_req = 1'b0;
            else if_addr = {$urandom, $urandom};
         end else if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = {$urandom, $urandom};
         end
         if (mem_done) begin
            if ($urandom_range(0, 1) == 0) mem_req = 1'b0;
            else begin
               mem_we = 1'($urandom_range(0, 1)); mem_addr = {$urandom, $urandom};
               mem_wdata = {$urandom, $urandom};
            end
         end else if (!mem_req && $urandom_range(0, 2) == 0) begin
            mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
            mem_addr = {$urandom, $urandom}; mem_wdata = {$urandom, $urandom};
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
